// File: rtl/sm_subtractor_pipe.sv
// Two-stage pipelined sign-magnitude subtractor (result = op_a - op_b) with valid/ready flow control.
// Define SM_SUB_SAT_EN to saturate the magnitude on overflow; otherwise the magnitude wraps.
module sm_subtractor_pipe #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int MAG_W = WIDTH - 1;

`ifdef SM_SUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // FRAC_BITS only names the binary point; it must still fit inside the magnitude.
    if (FRAC_BITS < 0 || FRAC_BITS > MAG_W) begin : g_bad_frac
        $error("sm_subtractor_pipe: FRAC_BITS out of range");
    end

    // On overflow the magnitude either saturates to all ones or keeps the wrapped low bits.
    function automatic logic [MAG_W-1:0] sat_mag(input logic ovf_bit, input logic [MAG_W-1:0] mag);
        return (SAT_EN && ovf_bit) ? {MAG_W{1'b1}} : mag;
    endfunction

    // Zero magnitude always carries a positive sign so -0 is never emitted.
    function automatic logic [WIDTH-1:0] pack_sm(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign & (mag != '0), mag};
    endfunction

    logic             sign_a;
    logic             sign_b_neg;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             eff_sub;
    logic             a_ge_b;

    logic [MAG_W-1:0] mag_hi_p1;
    logic [MAG_W-1:0] mag_lo_p1;
    logic             sub_p1;
    logic             sign_p1;
    logic             vld_p1;

    logic             adv_p2;
    logic             s1_open;

    logic [MAG_W:0]   sum_ext;
    logic [MAG_W-1:0] res_mag;
    logic             res_ovf;

    assign adv_p2   = !out_valid || out_ready;
    assign s1_open  = !vld_p1 || adv_p2;
    assign in_ready = !rst && s1_open;

    // Decode: subtracting op_b is adding op_b with its sign flipped.
    always_comb begin
        sign_a     = op_a[WIDTH-1];
        sign_b_neg = ~op_b[WIDTH-1];
        mag_a      = op_a[MAG_W-1:0];
        mag_b      = op_b[MAG_W-1:0];
        eff_sub    = (sign_a != sign_b_neg);
        a_ge_b     = (mag_a >= mag_b);
    end

    // ---- S1: ordered magnitudes, operation and result sign ----
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sub_p1 <= eff_sub;
            if (!eff_sub || a_ge_b) begin
                mag_hi_p1 <= mag_a;
                mag_lo_p1 <= mag_b;
                sign_p1   <= sign_a;
            end else begin
                mag_hi_p1 <= mag_b;
                mag_lo_p1 <= mag_a;
                sign_p1   <= sign_b_neg;
            end
        end
    end

    // Execute: SUB always has the larger magnitude as minuend, so only ADD can overflow.
    always_comb begin
        sum_ext = {1'b0, mag_hi_p1} + {1'b0, mag_lo_p1};
        res_ovf = 1'b0;
        res_mag = mag_hi_p1 - mag_lo_p1;
        if (!sub_p1) begin
            res_ovf = sum_ext[MAG_W];
            res_mag = sat_mag(sum_ext[MAG_W], sum_ext[MAG_W-1:0]);
        end
    end

    // ---- S2: output register, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv_p2) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    result <= pack_sm(sign_p1, res_mag);
                    ovf    <= res_ovf;
                end
            end
            if (s1_open) begin
                vld_p1 <= in_valid;
            end
        end
    end

endmodule

// File: tb/tb_sm_subtractor_pipe.sv
// Randomized bench for sm_subtractor_pipe: an integer-arithmetic reference model with a scoreboard,
// plus directed cases with literal expectations.
module tb_sm_subtractor_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    logic         stall_pending = 1'b0;
    logic [W-1:0] held_res;
    logic         held_ovf;

    sm_subtractor_pipe #(.WIDTH(W), .FRAC_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: treat operands as signed integers, subtract, then re-encode in sign-magnitude.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int va, vb, d, m, mx;
        mx = (1 << (W - 1)) - 1;
        va = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
        vb = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
        d  = va - vb;
        m  = (d < 0) ? -d : d;
        e.ovf = (m > mx);
        if (e.ovf) begin
`ifdef SM_SUB_SAT_EN
            m = mx;
`else
            m = m & mx;
`endif
        end
        e.res = {(d < 0) && (m != 0), m[W-2:0]};
        e.cyc = cyc;
        return e;
    endfunction

    // Scoreboard: transfers are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_pending = 1'b0;
            check("in_ready_in_reset", in_ready, 0);
        end else begin
            if (stall_pending) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_result_held", {ovf, result}, {held_ovf, held_res});
            end
            if (out_valid && q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_output: got result %0h with nothing outstanding (cycle %0d)", result, cyc);
            end else if (out_valid && out_ready) begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("ovf", ovf, e.ovf);
                check("latency_at_least_2", (cyc - e.cyc) >= 2, 1);
            end
            stall_pending = out_valid && !out_ready;
            held_res      = result;
            held_ovf      = ovf;
            if (in_valid && in_ready) q.push_back(model(op_a, op_b));
        end
    end

    // Sends one operand pair into an idle pipe with out_ready=1 and checks literal result and latency.
    task automatic send_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_r, input logic exp_o);
        int k;
        int lat;
        @(posedge clk); #1;
        op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        #2;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #3; k++; end
        check({name, "_accept_timeout"}, k < 20, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #3; lat++; end
        check({name, "_latency"}, lat, 2);
        check({name, "_result"}, result, exp_r);
        check({name, "_ovf"}, ovf, exp_o);
    endtask

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return {1'($urandom_range(0, 1)), 15'h7FFF};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int outs;
        int first;
        int last;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("post_reset_in_ready", in_ready, 1);

        send_one("pos_sub", 16'h0300, 16'h0100, 16'h0200, 1'b0);
        send_one("neg_sub", 16'h0100, 16'h0300, 16'h8200, 1'b0);
        send_one("mixed",   16'h8100, 16'h0200, 16'h8300, 1'b0);
        send_one("eq_neg",  16'h8100, 16'h8100, 16'h0000, 1'b0);
        send_one("neg_zero",16'h8000, 16'h0000, 16'h0000, 1'b0);
`ifdef SM_SUB_SAT_EN
        send_one("overflow",16'h7F00, 16'hFF00, 16'h7FFF, 1'b1);
`else
        send_one("overflow",16'h7F00, 16'hFF00, 16'h7E00, 1'b1);
`endif

        // Back-to-back: eight inputs, results on consecutive cycles.
        first = -1; last = -1; outs = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 8); out_ready = 1'b1;
            op_a = pick_op(); op_b = pick_op();
            #2;
            if (i < 8) check("b2b_in_ready", in_ready, 1);
            if (out_valid) begin
                outs++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("b2b_count", outs, 8);
        check("b2b_contiguous", last - first + 1, 8);

        // Backpressure: exactly two buffered, then in_ready drops.
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0;
            op_a = pick_op(); op_b = pick_op();
            #2;
            if (in_ready) acc++;
        end
        check("bp_accepted", acc, 2);
        check("bp_in_ready_low", in_ready, 0);
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            #2;
            if (out_valid) outs++;
        end
        check("bp_released_count", outs, 2);

        // Reset with both stages full.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0;
            op_a = pick_op(); op_b = pick_op();
        end
        #2;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_in_ready", in_ready, 1);
        send_one("after_rst", 16'h0300, 16'h0100, 16'h0200, 1'b0);

        // Random traffic with random backpressure and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op_a = pick_op(); op_b = pick_op();
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
